pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage MINA pipeline; it works alongside the forwarding unit.
- Handles three cases that forwarding cannot resolve: load-use hazards, data-memory wait states and EX-stage branch redirects.
- Drives per-stage stall, bubble and flush controls to the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- A wait-cycle counter detects hung memory accesses and latches a sticky fault.

Parameters:
- MEM_TIMEOUT, 64: consecutive wait cycles after which the block enters FAULT. Legal range 2..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ra_addr_if_id  in  regaddr_t  source A of the instruction in ID.
- rb_addr_if_id  in  regaddr_t  source B of the instruction in ID.
- ra_used_if_id  in  1  source A is actually read.
- rb_used_if_id  in  1  source B is actually read.
- rd_addr_id_ex  in  regaddr_t  destination of the instruction in EX.
- load_id_ex  in  1  instruction in EX is a load.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- dmem_req  in  1  MEM stage has an active data access.
- dmem_ack  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold IF/ID.
- flush_if_id  out  1  clear IF/ID to a NOP.
- stall_id_ex  out  1  hold ID/EX.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- stall_ex_mem  out  1  hold EX/MEM.
- bubble_mem_wb  out  1  load a NOP into MEM/WB.
- mem_fault  out  1  sticky memory-timeout fault.
- state_o  out  2  current state, for debug.

Behaviour:
- Reset is asynchronous: state goes to RUN, the counter goes to 0, and all outputs read 0 while rst is high.
- Reset mid-wait abandons the wait with no further outputs.
- States: RUN=0, MEM_WAIT=1, FAULT=2. Encoding 3 is unreachable and recovers to RUN.
- freeze = dmem_req & ~dmem_ack, or state==FAULT. The outputs below are combinational from the registered state and the current inputs.
- Priority order: freeze > branch > load-use. At most one class of action is applied per cycle.
- Freeze:
  - Assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and bubble_mem_wb.
  - flush_if_id and bubble_id_ex stay 0.
  - A branch_taken_ex during freeze is ignored. EX is held, so the branch re-presents after the freeze.
- Branch (not frozen, branch_taken_ex=1):
  - Assert flush_if_id and bubble_id_ex; all stalls stay 0.
  - A simultaneous load-use hazard is suppressed, because the ID instruction is discarded.
- Load-use (not frozen, no branch):
  - Hazard = load_id_ex & ((ra_used_if_id & ra_addr_if_id==rd_addr_id_ex) | (rb_used_if_id & rb_addr_if_id==rd_addr_id_ex)).
  - No register is special-cased.
  - Assert stall_pc, stall_if_id and bubble_id_ex for exactly 1 cycle. The bubble removes the load from ID/EX, so the hazard clears naturally.
- FSM transitions:
  - RUN -> MEM_WAIT when dmem_req & ~dmem_ack. The counter loads 1.
  - MEM_WAIT:
    - dmem_ack=1: go to RUN, counter to 0. The ack cycle itself is not frozen.
    - dmem_req drops without ack: go to RUN, counter to 0.
    - Otherwise the counter increments. When the counter equals MEM_TIMEOUT with no ack, go to FAULT.
  - FAULT: terminal until rst. mem_fault=1 and the full freeze is held.
- An ack in the same cycle as the request (zero-wait access) produces no freeze and no state change.
- Back-to-back accesses: an ack cycle followed immediately by a new unacked request re-enters MEM_WAIT with the counter at 1.
- The counter saturates and never wraps.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds output ports perf_stall_cycles (32 bits) and perf_flushes (32 bits).
  - perf_stall_cycles increments every cycle stall_pc=1.
  - perf_flushes increments every cycle flush_if_id=1.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Load r3 in EX, ID reads ra=r3 with ra_used=1 -> stall_pc, stall_if_id and bubble_id_ex high for 1 cycle; next cycle (load_id_ex=0) all low.
- Same as above but ra_used=0 and rb=r5 -> no stall.
- dmem_req=1 with ack on the 4th cycle -> freeze outputs high for 3 cycles, state_o=1 during the wait, RUN on the ack cycle, counter back to 0.
- branch_taken_ex and a load-use hazard in the same cycle -> flush_if_id=1, bubble_id_ex=1, stall_pc=0.
- branch_taken_ex during MEM_WAIT -> flush_if_id=0 while frozen; flush asserts on the ack cycle if the branch is still presented.
- MEM_TIMEOUT=4, dmem_req held with no ack -> mem_fault=1 after the 4th wait cycle; stays 1 after dmem_req drops; cleared only by async rst asserted mid-cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and stall sequencer for the 5-stage MINA pipeline.
//
// Resolves the cases forwarding cannot: load-use hazards, data-memory wait
// states and EX-stage taken-branch redirects. A wait counter detects a hung
// data access and latches a sticky fault that only rst clears.
//
// Parameters:
//   MEM_TIMEOUT  consecutive wait cycles that trigger FAULT (2..255)
//   CNT_W        wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ra/rb_addr_if_id, ra/rb_used  sources of the instruction in ID
//   rd_addr_id_ex, load_id_ex     destination / load flag of the instruction in EX
//   branch_taken_ex               EX resolved a taken branch or jump
//   dmem_req, dmem_ack            MEM-stage data access handshake
//   stall_*, flush_if_id, bubble_* pipeline register controls
//   mem_fault                     sticky memory-timeout fault
//   state_o                       FSM state (RUN=0, MEM_WAIT=1, FAULT=2)
//   perf_stall_cycles, perf_flushes  only with PIPE_CTRL_PERF_EN defined
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds the performance counters).
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr_if_id,
    input  logic [4:0]  rb_addr_if_id,
    input  logic        ra_used_if_id,
    input  logic        rb_used_if_id,
    input  logic [4:0]  rd_addr_id_ex,
    input  logic        load_id_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        flush_if_id,
    output logic        stall_id_ex,
    output logic        bubble_id_ex,
    output logic        stall_ex_mem,
    output logic        bubble_mem_wb,
    output logic        mem_fault,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // The cycle that brings the count up to MEM_TIMEOUT is the one that faults.
    localparam logic [CNT_W-1:0] LAST_OK = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_wait;
    logic freeze;
    logic lu_hazard;

    assign mem_wait  = dmem_req & ~dmem_ack;
    assign freeze    = mem_wait | (state_q == S_FAULT);
    assign lu_hazard = load_id_ex &
                       ((ra_used_if_id & (ra_addr_if_id == rd_addr_id_ex)) |
                        (rb_used_if_id & (rb_addr_if_id == rd_addr_id_ex)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mem_wait) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_WAIT: begin
                    // Ack or a dropped request both end the wait.
                    if (!mem_wait) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_OK)
                            state_q <= S_FAULT;
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Priority freeze > branch > load-use; all controls forced low in reset.
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        flush_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        bubble_id_ex  = 1'b0;
        stall_ex_mem  = 1'b0;
        bubble_mem_wb = 1'b0;
        if (!rst) begin
            if (freeze) begin
                // EX is held, so a taken branch simply re-presents later.
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                stall_ex_mem  = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (branch_taken_ex) begin
                // The ID instruction is discarded, so its hazard is moot.
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (lu_hazard) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    assign mem_fault = (state_q == S_FAULT);
    assign state_o   = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_pc)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_if_id)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`endif

endmodule
